// File: rtl/lvl_state_array.sv
// Level-state store for the Sat Engine: per-level decided bin and
// backtracked flag, a sequential backtrack-level search with start/done
// handshake, backtrack apply with clearing of deeper levels, and bulk
// load/unload of all level states.
module lvl_state_array #(
    parameter int NUM_LVLS         = 16,
    parameter int WIDTH_BIN        = 10,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_LVL_STATES = WIDTH_BIN + 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 decide_valid_i,
    input  logic [WIDTH_LVL-1:0]                 decide_lvl_i,
    input  logic [WIDTH_BIN-1:0]                 cur_bin_num_i,
    input  logic                                 find_start_i,
    input  logic [WIDTH_LVL-1:0]                 max_lvl_i,
    output logic                                 find_done_o,
    output logic                                 find_fail_o,
    output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
    output logic [WIDTH_BIN-1:0]                 bkt_bin_o,
    output logic                                 busy_o,
    input  logic                                 apply_bkt_i,
    input  logic [WIDTH_LVL-1:0]                 bkt_lvl_i,
    input  logic                                 wr_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o
);

    localparam int                   PTR_W     = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;
    localparam logic [PTR_W-1:0]     LAST_PTR  = PTR_W'(NUM_LVLS - 1);
    localparam logic [WIDTH_LVL-1:0] LAST_LVL  = WIDTH_LVL'(NUM_LVLS - 1);
    localparam logic [WIDTH_LVL-1:0] LVL_LIMIT = WIDTH_LVL'(NUM_LVLS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [WIDTH_BIN-1:0] dcd_bin_q [NUM_LVLS];
    logic [WIDTH_BIN-1:0] dcd_bin_d [NUM_LVLS];
    logic [NUM_LVLS-1:0]  has_bkt_q;
    logic [NUM_LVLS-1:0]  has_bkt_d;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 prime_q, prime_d;
    logic                 fail_q, fail_d;
    logic [WIDTH_LVL-1:0] lvl_q, lvl_d;
    logic [WIDTH_BIN-1:0] bin_q, bin_d;

    logic                 busy;

    assign busy        = (state_q != IDLE);
    assign busy_o      = busy;
    assign find_done_o = (state_q == DONE);
    assign find_fail_o = fail_q;
    assign bkt_lvl_o   = lvl_q;
    assign bkt_bin_o   = bin_q;

    // Pack the level registers onto the unload bus, has_bkt in the LSB of each level
    always_comb begin
        lvl_states_o = '0;
        for (int k = 0; k < NUM_LVLS; k++) begin
            lvl_states_o[k*WIDTH_LVL_STATES +: WIDTH_LVL_STATES] = {dcd_bin_q[k], has_bkt_q[k]};
        end
    end

    // Level-state next value: bulk load beats backtrack apply beats decision
    always_comb begin
        dcd_bin_d = dcd_bin_q;
        has_bkt_d = has_bkt_q;
        if (wr_states_i) begin
            for (int k = 0; k < NUM_LVLS; k++) begin
                dcd_bin_d[k] = lvl_states_i[k*WIDTH_LVL_STATES + 1 +: WIDTH_BIN];
                has_bkt_d[k] = lvl_states_i[k*WIDTH_LVL_STATES];
            end
        end else if (apply_bkt_i && !busy) begin
            if (bkt_lvl_i < LVL_LIMIT) begin
                for (int k = 0; k < NUM_LVLS; k++) begin
                    if (WIDTH_LVL'(k) == bkt_lvl_i) begin
                        has_bkt_d[k] = 1'b1;
                    end else if (WIDTH_LVL'(k) > bkt_lvl_i) begin
                        dcd_bin_d[k] = '0;
                        has_bkt_d[k] = 1'b0;
                    end
                end
            end
        end else if (decide_valid_i && !busy) begin
            // Level 0 is the root and never carries a decision
            for (int k = 1; k < NUM_LVLS; k++) begin
                if (WIDTH_LVL'(k) == decide_lvl_i) begin
                    dcd_bin_d[k] = cur_bin_num_i;
                    has_bkt_d[k] = 1'b0;
                end
            end
        end
    end

    // Search FSM next state: walk down from the clamped max level to the first non-backtracked level
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        prime_d = 1'b0;
        fail_d  = fail_q;
        lvl_d   = lvl_q;
        bin_d   = bin_q;
        if (wr_states_i) begin
            // A bulk load invalidates any search in flight; abort silently
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (find_start_i) begin
                        state_d = SCAN;
                        ptr_d   = (max_lvl_i >= LAST_LVL) ? LAST_PTR : max_lvl_i[PTR_W-1:0];
                        prime_d = 1'b1;
                        fail_d  = 1'b0;
                        lvl_d   = '0;
                        bin_d   = '0;
                    end
                end
                SCAN: begin
                    // The first SCAN cycle only aligns the search so that done
                    // lands a fixed two cycles after the start edge for a hit at max.
                    if (prime_q) begin
                        state_d = SCAN;
                    end else if (ptr_q == '0) begin
                        fail_d  = 1'b1;
                        state_d = DONE;
                    end else if (!has_bkt_q[ptr_q]) begin
                        lvl_d   = WIDTH_LVL'(ptr_q);
                        bin_d   = dcd_bin_q[ptr_q];
                        state_d = DONE;
                    end else begin
                        ptr_d = ptr_q - PTR_W'(1);
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Register all state; active-low synchronous reset clears everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_LVLS; k++) begin
                dcd_bin_q[k] <= '0;
            end
            has_bkt_q <= '0;
            state_q   <= IDLE;
            ptr_q     <= '0;
            prime_q   <= 1'b0;
            fail_q    <= 1'b0;
            lvl_q     <= '0;
            bin_q     <= '0;
        end else begin
            dcd_bin_q <= dcd_bin_d;
            has_bkt_q <= has_bkt_d;
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            prime_q   <= prime_d;
            fail_q    <= fail_d;
            lvl_q     <= lvl_d;
            bin_q     <= bin_d;
        end
    end

endmodule

// File: tb/tb_lvl_state_array.sv
// Bench for lvl_state_array: directed vectors, a behavioural model checked
// every cycle, and literal expectations from hand-worked scenarios.
module tb_lvl_state_array;

    localparam int NL = 16;
    localparam int BW = 10;
    localparam int LW = 16;
    localparam int SW = BW + 1;
    localparam int TW = SW * NL;

    logic          clk;
    logic          rst;
    logic          decide_valid_i;
    logic [LW-1:0] decide_lvl_i;
    logic [BW-1:0] cur_bin_num_i;
    logic          find_start_i;
    logic [LW-1:0] max_lvl_i;
    logic          find_done_o;
    logic          find_fail_o;
    logic [LW-1:0] bkt_lvl_o;
    logic [BW-1:0] bkt_bin_o;
    logic          busy_o;
    logic          apply_bkt_i;
    logic [LW-1:0] bkt_lvl_i;
    logic          wr_states_i;
    logic [TW-1:0] lvl_states_i;
    logic [TW-1:0] lvl_states_o;

    int n_vec = 0;
    int n_err = 0;

    lvl_state_array #(
        .NUM_LVLS(NL), .WIDTH_BIN(BW), .WIDTH_LVL(LW), .WIDTH_LVL_STATES(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .decide_valid_i(decide_valid_i), .decide_lvl_i(decide_lvl_i), .cur_bin_num_i(cur_bin_num_i),
        .find_start_i(find_start_i), .max_lvl_i(max_lvl_i),
        .find_done_o(find_done_o), .find_fail_o(find_fail_o),
        .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o), .busy_o(busy_o),
        .apply_bkt_i(apply_bkt_i), .bkt_lvl_i(bkt_lvl_i),
        .wr_states_i(wr_states_i), .lvl_states_i(lvl_states_i), .lvl_states_o(lvl_states_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [BW-1:0] m_bin [NL];
    logic [NL-1:0] m_bkt;
    logic          m_busy, m_done, m_fail;
    logic [LW-1:0] m_lvl;
    logic [BW-1:0] m_obin;
    int            m_cnt, m_max;
    bit            mdl_ok = 1'b0;
    logic [TW-1:0] exp_states;

    function automatic int clamp_lvl(input int m);
        return (m > NL - 1) ? NL - 1 : m;
    endfunction

    // Deepest level at or below the clamped max that is not yet backtracked; -1 if none above root
    function automatic int find_level(input int m);
        for (int l = clamp_lvl(m); l >= 1; l--) begin
            if (m_bkt[l] == 1'b0) return l;
        end
        return -1;
    endfunction

    function automatic int lat_of(input int m);
        int f;
        f = find_level(m);
        return (f < 0) ? 2 + clamp_lvl(m) : 2 + clamp_lvl(m) - f;
    endfunction

    function automatic logic [BW-1:0] found_bin(input int m);
        int f;
        f = find_level(m);
        return (f < 0) ? '0 : m_bin[f];
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NL; k++) m_bin[k] <= '0;
            m_bkt  <= '0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_fail <= 1'b0;
            m_lvl  <= '0;
            m_obin <= '0;
            m_cnt  <= 0;
            m_max  <= 0;
            mdl_ok <= 1'b1;
        end else begin
            if (wr_states_i) begin
                for (int k = 0; k < NL; k++) begin
                    m_bin[k] <= lvl_states_i[k*SW+1 +: BW];
                    m_bkt[k] <= lvl_states_i[k*SW];
                end
            end else if (apply_bkt_i && !m_busy) begin
                for (int k = 0; k < NL; k++) begin
                    if (int'(bkt_lvl_i) == k) m_bkt[k] <= 1'b1;
                    else if (int'(bkt_lvl_i) < k) begin
                        m_bin[k] <= '0;
                        m_bkt[k] <= 1'b0;
                    end
                end
            end else if (decide_valid_i && !m_busy && decide_lvl_i != 0 && int'(decide_lvl_i) < NL) begin
                m_bin[decide_lvl_i] <= cur_bin_num_i;
                m_bkt[decide_lvl_i] <= 1'b0;
            end

            if (wr_states_i) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end else if (!m_busy) begin
                m_done <= 1'b0;
                if (find_start_i) begin
                    m_busy <= 1'b1;
                    m_max  <= int'(max_lvl_i);
                    m_cnt  <= lat_of(int'(max_lvl_i));
                    m_fail <= 1'b0;
                    m_lvl  <= '0;
                    m_obin <= '0;
                end
            end else if (m_done) begin
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_fail <= (find_level(m_max) < 0);
                    m_lvl  <= (find_level(m_max) < 0) ? '0 : LW'(find_level(m_max));
                    m_obin <= found_bin(m_max);
                end
            end
        end
    end

    always_comb begin
        exp_states = '0;
        for (int k = 0; k < NL; k++) exp_states[k*SW +: SW] = {m_bin[k], m_bkt[k]};
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("states", lvl_states_o, exp_states);
            chk("busy", busy_o, m_busy);
            chk("done", find_done_o, m_done);
            chk("fail", find_fail_o, m_fail);
            chk("bkt_lvl", bkt_lvl_o, m_lvl);
            chk("bkt_bin", bkt_bin_o, m_obin);
        end
    end

    // ---------------- stimulus ----------------
    logic [TW-1:0] ld;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic decide(input int l, input int b);
        decide_valid_i = 1'b1;
        decide_lvl_i   = LW'(l);
        cur_bin_num_i  = BW'(b);
        tick();
        decide_valid_i = 1'b0;
    endtask

    task automatic apply(input int l);
        apply_bkt_i = 1'b1;
        bkt_lvl_i   = LW'(l);
        tick();
        apply_bkt_i = 1'b0;
    endtask

    task automatic set_lvl(input int k, input int b, input logic h);
        ld[k*SW +: SW] = {BW'(b), h};
    endtask

    task automatic load();
        wr_states_i  = 1'b1;
        lvl_states_i = ld;
        tick();
        wr_states_i  = 1'b0;
    endtask

    // Start a search and count cycles to the done pulse (-1 if it never comes)
    task automatic run_search(input int m, output int lat);
        find_start_i = 1'b1;
        max_lvl_i    = LW'(m);
        tick();
        find_start_i = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (find_done_o) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        bit  saw_done;
        rst = 1'b0;
        decide_valid_i = 1'b0; decide_lvl_i = '0; cur_bin_num_i = '0;
        find_start_i = 1'b0; max_lvl_i = '0;
        apply_bkt_i = 1'b0; bkt_lvl_i = '0;
        wr_states_i = 1'b0; lvl_states_i = '0;
        ld = '0;
        tick(); tick();
        chk("rst_states", lvl_states_o, 0);
        chk("rst_busy", busy_o, 0);
        rst = 1'b1;
        tick();

        // 1: decisions on levels 1..3; a level-0 decision is ignored
        decide(1, 5); decide(2, 9); decide(3, 12); decide(0, 7);
        chk("t1_l0", lvl_states_o[0*SW +: SW], 11'd0);
        chk("t1_l1", lvl_states_o[1*SW +: SW], 11'd10);
        chk("t1_l2", lvl_states_o[2*SW +: SW], 11'd18);
        chk("t1_l3", lvl_states_o[3*SW +: SW], 11'd24);
        chk("t1_rest", lvl_states_o[TW-1:4*SW], 0);

        // 2: level 3 backtracked -> level 2 found
        apply(3);
        run_search(3, lat);
        chk("t2_lat", lat, 3);
        chk("t2_lvl", bkt_lvl_o, 2);
        chk("t2_bin", bkt_bin_o, 9);
        chk("t2_fail", find_fail_o, 0);
        tick();

        // 3: levels 1..3 all backtracked -> fail
        ld = '0;
        set_lvl(1, 5, 1'b1); set_lvl(2, 9, 1'b1); set_lvl(3, 12, 1'b1);
        load();
        run_search(3, lat);
        chk("t3_lat", lat, 5);
        chk("t3_fail", find_fail_o, 1);
        chk("t3_lvl", bkt_lvl_o, 0);
        chk("t3_bin", bkt_bin_o, 0);
        tick();

        // 4: backtrack to level 1 clears levels 2..5
        ld = '0;
        set_lvl(1, 5, 1'b0); set_lvl(2, 9, 1'b0); set_lvl(3, 12, 1'b1);
        set_lvl(4, 7, 1'b0); set_lvl(5, 3, 1'b1);
        load();
        apply(1);
        chk("t4_l1", lvl_states_o[1*SW +: SW], 11'd11);
        chk("t4_l2_5", lvl_states_o[6*SW-1:2*SW], 0);

        // 5: max level beyond the array clamps to 15
        decide(15, 777);
        run_search(100, lat);
        chk("t5_lat", lat, 2);
        chk("t5_lvl", bkt_lvl_o, 15);
        chk("t5_bin", bkt_bin_o, 777);
        chk("t5_fail", find_fail_o, 0);
        tick();

        // 6a: bulk load during SCAN aborts the search with no done pulse
        ld = '0;
        for (int k = 1; k < NL; k++) set_lvl(k, k, 1'b1);
        load();
        find_start_i = 1'b1; max_lvl_i = LW'(15);
        tick();
        find_start_i = 1'b0;
        tick(); tick();
        ld = '0;
        for (int k = 1; k < NL; k++) set_lvl(k, 2 * k, 1'b0);
        load();
        chk("t6a_busy", busy_o, 0);
        chk("t6a_states", lvl_states_o, ld);
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (find_done_o) saw_done = 1'b1;
        end
        chk("t6a_nodone", saw_done, 0);

        // 6b: decide and apply while busy are ignored
        ld = '0;
        for (int k = 1; k < NL; k++) set_lvl(k, k, 1'b1);
        load();
        find_start_i = 1'b1; max_lvl_i = LW'(15);
        tick();
        find_start_i = 1'b0;
        tick();
        decide_valid_i = 1'b1; decide_lvl_i = LW'(4); cur_bin_num_i = BW'(99);
        tick();
        decide_valid_i = 1'b0;
        apply_bkt_i = 1'b1; bkt_lvl_i = LW'(2);
        tick();
        apply_bkt_i = 1'b0;
        lat = -1;
        for (int k = 4; k <= 60; k++) begin
            tick();
            if (find_done_o) begin
                lat = k;
                break;
            end
        end
        chk("t6b_lat", lat, 17);
        chk("t6b_fail", find_fail_o, 1);
        chk("t6b_l4", lvl_states_o[4*SW +: SW], 11'd9);
        chk("t6b_l3", lvl_states_o[3*SW +: SW], 11'd7);
        tick();

        // 6c: reset mid-SCAN clears everything
        find_start_i = 1'b1; max_lvl_i = LW'(15);
        tick();
        find_start_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("t6c_busy", busy_o, 0);
        chk("t6c_done", find_done_o, 0);
        chk("t6c_fail", find_fail_o, 0);
        chk("t6c_lvl", bkt_lvl_o, 0);
        chk("t6c_bin", bkt_bin_o, 0);
        chk("t6c_states", lvl_states_o, 0);
        rst = 1'b1;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
